tff_counter_sync: RTL and testbench

- Parametrised synchronous up/down modulo counter built from a bank of T flip-flops: each bit toggles when its computed T input is 1.
- Generalises the single-bit T flip-flop with:
  - a configurable width and modulus;
  - synchronous reset, parallel load and count enable;
  - terminal-count and wrap flags.
- Used as the standard counter primitive for timers and dividers in this design.

---
 rtl/tff_pkg.sv | 59 +++++
 rtl/tff_counter_sync_if.sv | 25 ++
 rtl/tff_cell.sv | 30 +++
 rtl/tff_counter_sync.sv | 117 +++++++++++
 tb/tb_tff_counter_sync.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tff_pkg.sv
// Shared definitions for the T flip-flop counter: direction constants and
// the toggle-vector helper used to build q_next = q ^ tvec.
package tff_pkg;

    localparam logic CNT_DOWN  = 1'b0;
    localparam logic CNT_UP    = 1'b1;
    localparam int   MAX_WIDTH = 32;

    // Ceiling log2 of a 64-bit value; clog2(1) = 0, clog2(16) = 4, clog2(10) = 4.
    function automatic int clog2(input logic [63:0] value);
        logic [63:0] v;
        int          r;
        v = value - 64'd1;
        r = 0;
        for (int i = 0; i < 64; i++) begin
            if (v[i]) r = i + 1;
        end
        return r;
    endfunction

    // Per-bit T vector that moves q one step in the requested direction,
    // wrapping at the ends of 0..modulus-1.
    // Power-of-two moduli use the classic toggle chain limited to log2(modulus)
    // bits (so wrap falls out of the carry naturally); other moduli compute the
    // target value and toggle exactly the differing bits.
    function automatic logic [MAX_WIDTH-1:0] tvec_calc(
        input logic [MAX_WIDTH-1:0] q,
        input logic                 up_dn,
        input logic [63:0]          modulus
    );
        logic [MAX_WIDTH-1:0] tvec;
        logic [MAX_WIDTH-1:0] target;
        logic [MAX_WIDTH-1:0] max_val;
        logic                 carry;
        int                   nbits;
        tvec    = '0;
        target  = '0;
        carry   = 1'b1;
        max_val = MAX_WIDTH'(modulus - 64'd1);
        nbits   = clog2(modulus);
        if ((modulus & (modulus - 64'd1)) == 64'd0) begin
            for (int i = 0; i < MAX_WIDTH; i++) begin
                if (i < nbits) begin
                    tvec[i] = carry;
                    carry   = carry & ((up_dn == CNT_UP) ? q[i] : ~q[i]);
                end
            end
        end else begin
            if (up_dn == CNT_UP) begin
                target = (q == max_val) ? '0 : q + 32'd1;
            end else begin
                target = (q == '0) ? max_val : q - 32'd1;
            end
            tvec = q ^ target;
        end
        return tvec;
    endfunction

endpackage

// File: rtl/tff_counter_sync_if.sv
// Control/status bundle of the T flip-flop counter. The master drives the
// count controls; the slave (the counter) returns state and flags.
interface tff_counter_sync_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_inverse;
    logic             tc;
    logic             wrap;
    logic             load_err;

    modport master (
        output en, up_dn, load, load_val,
        input  q, q_inverse, tc, wrap, load_err
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output q, q_inverse, tc, wrap, load_err
    );
endinterface

// File: rtl/tff_cell.sv
// One T flip-flop with synchronous reset to rst_val and a synchronous load
// that overrides t. q_inverse is its own register so it never lags q.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic t,
    input  logic ld,
    input  logic d,
    output logic q,
    output logic q_inverse
);

    // Bit state: reset > load > toggle, otherwise hold.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            q         <= rst_val;
            q_inverse <= ~rst_val;
        end else if (ld) begin
            q         <= d;
            q_inverse <= ~d;
        end else if (t) begin
            q         <= ~q;
            q_inverse <= q;
        end
    end

endmodule

// File: rtl/tff_counter_sync.sv
// Parametrised synchronous up/down modulo counter built from WIDTH T flip-flops.
// Priority per edge: rst > load > en. Out-of-range loads clamp to MODULUS-1
// and pulse load_err; wrapping pulses wrap.
// Optional build macro TFF_COUNTER_SATURATE_EN: the counter saturates at both
// ends instead of wrapping and wrap is tied to 0.
module tff_counter_sync
    import tff_pkg::*;
#(
    parameter int              WIDTH     = 4,
    parameter longint unsigned MODULUS   = 16,
    parameter longint unsigned RESET_VAL = 0
) (
    input  logic               clk,
    input  logic               rst,
    tff_counter_sync_if.slave  bus
);

    // Parameter legality is checked at elaboration.
    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("tff_counter_sync: WIDTH must be 1..32");
    end
    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
        $error("tff_counter_sync: MODULUS must be 2..2**WIDTH");
    end
    if (RESET_VAL >= MODULUS) begin : g_bad_reset
        $error("tff_counter_sync: RESET_VAL must be below MODULUS");
    end

    localparam logic [63:0]      MOD64   = 64'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_inverse;
    logic [WIDTH-1:0] tvec;
    logic [WIDTH-1:0] load_d;
    logic             tc;
    logic             load_oor;
    logic             load_err_r;

    // Terminal count: last value in the current direction, independent of en.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        tc = 1'b0;
        if (bus.up_dn == CNT_UP) begin
            tc = (q == MAX_VAL);
        end else begin
            tc = (q == '0);
        end
    end

    // Toggle vector for the next edge; zero when disabled (or pinned at an end
    // in the saturating build).
    always_comb begin
        tvec = '0;
        if (bus.en) begin
            tvec = WIDTH'(tvec_calc(MAX_WIDTH'(q), bus.up_dn, MOD64));
        end
`ifdef TFF_COUNTER_SATURATE_EN
        if (tc) begin
            tvec = '0;
        end
`endif
    end

    // Load value clamped into range; the clamp itself is the error condition.
    always_comb begin
        load_oor = (64'(bus.load_val) >= MOD64);
        load_d   = load_oor ? MAX_VAL : bus.load_val;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk       (clk),
            .rst       (rst),
            .rst_val   (RST_VAL[i]),
            .t         (tvec[i]),
            .ld        (bus.load),
            .d         (load_d[i]),
            .q         (q[i]),
            .q_inverse (q_inverse[i])
        );
    end

    // load_err: one-cycle pulse after a clamped load, cleared by anything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_err_r <= 1'b0;
        end else begin
            load_err_r <= bus.load & load_oor;
        end
    end

`ifdef TFF_COUNTER_SATURATE_EN
    assign bus.wrap = 1'b0;
`else
    logic wrap_r;

    // wrap: one-cycle pulse after a counting edge taken at the terminal count.
    always_ff @(posedge clk) begin
        if (rst || bus.load) begin
            wrap_r <= 1'b0;
        end else begin
            wrap_r <= bus.en & tc;
        end
    end

    assign bus.wrap = wrap_r;
`endif

    assign bus.q         = q;
    assign bus.q_inverse = q_inverse;
    assign bus.tc        = tc;
    assign bus.load_err  = load_err_r;

endmodule

// File: tb/tb_tff_counter_sync.sv
// Self-checking bench for tff_counter_sync: directed vector tables for the
// WIDTH=4/MODULUS=10 and single-bit instances, a hand sequence for tc versus
// up_dn, then randomized stimulus on three more configurations compared to a
// modular-arithmetic reference model.
module tb_tff_counter_sync;

    typedef struct {
        bit       rst;
        bit       load;
        bit [3:0] load_val;
        bit       en;
        bit       up_dn;
        bit [3:0] q;
        bit       tc;
        bit       wrap;
        bit       le;
    } vec_t;

    typedef struct {
        bit     rst;
        bit     load;
        longint lv;
        bit     en;
        bit     up;
    } stim_t;

    typedef struct {
        longint q;
        bit     wrap;
        bit     le;
    } model_t;

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c, rst_d, rst_e;

    tff_counter_sync_if #(.WIDTH(4)) if_a ();
    tff_counter_sync_if #(.WIDTH(1)) if_b ();
    tff_counter_sync_if #(.WIDTH(4)) if_c ();
    tff_counter_sync_if #(.WIDTH(3)) if_d ();
    tff_counter_sync_if #(.WIDTH(4)) if_e ();

    tff_counter_sync #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut_a (.clk(clk), .rst(rst_a), .bus(if_a.slave));
    tff_counter_sync #(.WIDTH(1), .MODULUS(2),  .RESET_VAL(0)) dut_b (.clk(clk), .rst(rst_b), .bus(if_b.slave));
    tff_counter_sync #(.WIDTH(4), .MODULUS(16), .RESET_VAL(5)) dut_c (.clk(clk), .rst(rst_c), .bus(if_c.slave));
    tff_counter_sync #(.WIDTH(3), .MODULUS(5),  .RESET_VAL(3)) dut_d (.clk(clk), .rst(rst_d), .bus(if_d.slave));
    tff_counter_sync #(.WIDTH(4), .MODULUS(8),  .RESET_VAL(7)) dut_e (.clk(clk), .rst(rst_e), .bus(if_e.slave));

    vec_t vecs_a[$];
    vec_t vecs_b[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit rst, bit load, bit [3:0] lv, bit en, bit up,
                                bit [3:0] q, bit tc, bit wrap, bit le);
        vec_t v;
        v.rst = rst; v.load = load; v.load_val = lv; v.en = en; v.up_dn = up;
        v.q = q; v.tc = tc; v.wrap = wrap; v.le = le;
        return v;
    endfunction

    // Reference behaviour: plain modular arithmetic on the count value.
    function automatic model_t model_next(model_t s, stim_t st, longint m, longint rv);
        model_t r;
        r.q = s.q; r.wrap = 1'b0; r.le = 1'b0;
        if (st.rst) begin
            r.q = rv;
        end else if (st.load) begin
            if (st.lv >= m) begin
                r.q = m - 1; r.le = 1'b1;
            end else begin
                r.q = st.lv;
            end
        end else if (st.en) begin
`ifdef TFF_COUNTER_SATURATE_EN
            if (st.up) r.q = (s.q == m - 1) ? s.q : s.q + 1;
            else       r.q = (s.q == 0) ? 0 : s.q - 1;
`else
            if (st.up) begin
                r.q = (s.q + 1) % m; r.wrap = (s.q + 1 == m);
            end else begin
                r.q = (s.q + m - 1) % m; r.wrap = (s.q == 0);
            end
`endif
        end
        return r;
    endfunction

    function automatic stim_t rand_stim(longint lv_max, bit prev_up, bit force_rst);
        stim_t st;
        st.rst  = force_rst || ($urandom_range(0, 31) == 0);
        st.load = ($urandom_range(0, 7) == 0);
        st.lv   = longint'($urandom_range(0, int'(lv_max)));
        st.en   = ($urandom_range(0, 3) != 0);
        st.up   = ($urandom_range(0, 7) == 0) ? ~prev_up : prev_up;
        return st;
    endfunction

    task automatic verify(input string tag, input logic [63:0] q, input logic [63:0] qi,
                          input logic tc, input logic wrap, input logic le,
                          input model_t mdl, input stim_t st, input longint m, input int w);
        logic [63:0] mask;
        logic        exp_tc;
        mask   = (64'd1 << w) - 64'd1;
        exp_tc = st.up ? (mdl.q == m - 1) : (mdl.q == 0);
        check({tag, ".q"},         q,  64'(mdl.q));
        check({tag, ".q_inverse"}, qi, mask ^ 64'(mdl.q));
        check({tag, ".tc"},        64'(tc),   64'(exp_tc));
        check({tag, ".wrap"},      64'(wrap), 64'(mdl.wrap));
        check({tag, ".load_err"},  64'(le),   64'(mdl.le));
    endtask

    task automatic run_a(input vec_t t, input int idx);
        logic [3:0] qi;
        @(negedge clk);
        rst_a = t.rst; if_a.load = t.load; if_a.load_val = t.load_val;
        if_a.en = t.en; if_a.up_dn = t.up_dn;
        @(posedge clk);
        #1;
        qi = ~t.q;
        check($sformatf("A[%0d].q", idx),         64'(if_a.q),         64'(t.q));
        check($sformatf("A[%0d].q_inverse", idx), 64'(if_a.q_inverse), 64'(qi));
        check($sformatf("A[%0d].tc", idx),        64'(if_a.tc),        64'(t.tc));
        check($sformatf("A[%0d].wrap", idx),      64'(if_a.wrap),      64'(t.wrap));
        check($sformatf("A[%0d].load_err", idx),  64'(if_a.load_err),  64'(t.le));
    endtask

    task automatic run_b(input vec_t t, input int idx);
        logic qb, qib;
        @(negedge clk);
        rst_b = t.rst; if_b.load = t.load; if_b.load_val = t.load_val[0];
        if_b.en = t.en; if_b.up_dn = t.up_dn;
        @(posedge clk);
        #1;
        qb  = t.q[0];
        qib = ~qb;
        check($sformatf("B[%0d].q", idx),         64'(if_b.q),         64'(qb));
        check($sformatf("B[%0d].q_inverse", idx), 64'(if_b.q_inverse), 64'(qib));
        check($sformatf("B[%0d].tc", idx),        64'(if_b.tc),        64'(t.tc));
        check($sformatf("B[%0d].wrap", idx),      64'(if_b.wrap),      64'(t.wrap));
    endtask

    initial begin
        model_t mc, md, me;
        stim_t  sc, sd, se;
        bit     uc, ud, ue;

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1; rst_e = 1'b1;
        if_a.en = 0; if_a.up_dn = 1; if_a.load = 0; if_a.load_val = '0;
        if_b.en = 0; if_b.up_dn = 1; if_b.load = 0; if_b.load_val = '0;
        if_c.en = 0; if_c.up_dn = 1; if_c.load = 0; if_c.load_val = '0;
        if_d.en = 0; if_d.up_dn = 1; if_d.load = 0; if_d.load_val = '0;
        if_e.en = 0; if_e.up_dn = 1; if_e.load = 0; if_e.load_val = '0;

        // ---- WIDTH=4, MODULUS=10 directed table ----
        vecs_a.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs_a.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0));
        for (int k = 1; k <= 12; k++) begin
`ifdef TFF_COUNTER_SATURATE_EN
            vecs_a.push_back(mk(0, 0, 0, 1, 1, (k > 9) ? 4'd9 : 4'(k), (k >= 9), 0, 0));
`else
            vecs_a.push_back(mk(0, 0, 0, 1, 1, 4'(k % 10), (k == 9), (k == 10), 0));
`endif
        end
        vecs_a.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0));
`ifdef TFF_COUNTER_SATURATE_EN
        vecs_a.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0));
        vecs_a.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0));
`else
        vecs_a.push_back(mk(0, 0, 0, 1, 0, 9, 0, 1, 0));
        vecs_a.push_back(mk(0, 0, 0, 1, 0, 8, 0, 0, 0));
`endif
        vecs_a.push_back(mk(0, 1, 9,  1, 1, 9, 1, 0, 0));
        vecs_a.push_back(mk(0, 1, 3,  1, 1, 3, 0, 0, 0));   // load beats a pending wrap
        vecs_a.push_back(mk(0, 1, 9,  1, 1, 9, 1, 0, 0));
        vecs_a.push_back(mk(0, 0, 0,  1, 0, 8, 0, 0, 0));   // direction change, no wrap
        vecs_a.push_back(mk(0, 1, 7,  1, 1, 7, 0, 0, 0));   // en ignored under load
        vecs_a.push_back(mk(0, 1, 12, 0, 1, 9, 1, 0, 1));
        vecs_a.push_back(mk(0, 0, 0,  0, 1, 9, 1, 0, 0));
        vecs_a.push_back(mk(0, 1, 10, 1, 0, 9, 0, 0, 1));   // load_val == MODULUS
        vecs_a.push_back(mk(0, 1, 15, 0, 1, 9, 1, 0, 1));
        vecs_a.push_back(mk(0, 1, 5,  0, 1, 5, 0, 0, 0));
        for (int k = 0; k < 3; k++) vecs_a.push_back(mk(0, 0, 0, 0, 1, 5, 0, 0, 0));
        vecs_a.push_back(mk(0, 1, 9,  0, 1, 9, 1, 0, 0));
        vecs_a.push_back(mk(1, 1, 3,  1, 1, 0, 0, 0, 0));   // rst beats load and en
        foreach (vecs_a[i]) run_a(vecs_a[i], i);

        // ---- tc follows up_dn immediately, q untouched ----
        run_a(mk(0, 1, 9, 0, 1, 9, 1, 0, 0), 100);
        @(negedge clk);
        if_a.load = 0; if_a.en = 0; if_a.up_dn = 0;
        #1 check("A.tc_down_at_9", 64'(if_a.tc), 64'(0));
        if_a.up_dn = 1;
        #1 check("A.tc_up_at_9", 64'(if_a.tc), 64'(1));
        if_a.up_dn = 0;
        @(posedge clk);
        #1 check("A.q_hold_after_dir", 64'(if_a.q), 64'(9));
        check("A.tc_down_after_edge", 64'(if_a.tc), 64'(0));

        // ---- WIDTH=1, MODULUS=2 T flip-flop table ----
        vecs_b.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0));
`ifdef TFF_COUNTER_SATURATE_EN
        vecs_b.push_back(mk(0, 0, 0, 1, 1, 1, 1, 0, 0));
        vecs_b.push_back(mk(0, 0, 0, 1, 1, 1, 1, 0, 0));
        vecs_b.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0));
        vecs_b.push_back(mk(0, 0, 0, 1, 1, 1, 1, 0, 0));
        vecs_b.push_back(mk(0, 0, 0, 1, 1, 1, 1, 0, 0));
`else
        vecs_b.push_back(mk(0, 0, 0, 1, 1, 1, 1, 0, 0));
        vecs_b.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, 0));
        vecs_b.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs_b.push_back(mk(0, 0, 0, 1, 1, 1, 1, 0, 0));
        vecs_b.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, 0));
`endif
        vecs_b.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0));
        foreach (vecs_b[i]) run_b(vecs_b[i], i);

        // ---- randomized configurations against the reference model ----
        mc = '{q: 0, wrap: 0, le: 0};
        md = mc; me = mc;
        uc = 1; ud = 1; ue = 1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            sc = rand_stim(15, uc, cyc == 0); uc = sc.up;
            sd = rand_stim(7,  ud, cyc == 0); ud = sd.up;
            se = rand_stim(15, ue, cyc == 0); ue = se.up;
            rst_c = sc.rst; if_c.load = sc.load; if_c.load_val = 4'(sc.lv); if_c.en = sc.en; if_c.up_dn = sc.up;
            rst_d = sd.rst; if_d.load = sd.load; if_d.load_val = 3'(sd.lv); if_d.en = sd.en; if_d.up_dn = sd.up;
            rst_e = se.rst; if_e.load = se.load; if_e.load_val = 4'(se.lv); if_e.en = se.en; if_e.up_dn = se.up;
            mc = model_next(mc, sc, 16, 5);
            md = model_next(md, sd, 5, 3);
            me = model_next(me, se, 8, 7);
            @(posedge clk);
            #1;
            verify($sformatf("C@%0d", cyc), 64'(if_c.q), 64'(if_c.q_inverse), if_c.tc, if_c.wrap, if_c.load_err, mc, sc, 16, 4);
            verify($sformatf("D@%0d", cyc), 64'(if_d.q), 64'(if_d.q_inverse), if_d.tc, if_d.wrap, if_d.load_err, md, sd, 5, 3);
            verify($sformatf("E@%0d", cyc), 64'(if_e.q), 64'(if_e.q_inverse), if_e.tc, if_e.wrap, if_e.load_err, me, se, 8, 4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
